// File: rtl/traffic_pkg.sv
// Shared lamp/state encodings and fault codes for the traffic light sequencer
// and its downstream lamp monitor.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_RED,
        S_RUN_GREEN,
        S_RUN_AMBER,
        S_GAP,
        S_FAILSAFE
    } lamp_state_e;

    typedef enum logic [1:0] {
        C_RED,
        C_GREEN,
        C_AMBER
    } colour_e;

    typedef struct packed {
        logic red;
        logic amber;
        logic green;
    } lamps_t;

    localparam logic [2:0] FLT_NONE     = 3'd0;
    localparam logic [2:0] FLT_CONFLICT = 3'd1;
    localparam logic [2:0] FLT_SEQUENCE = 3'd2;
    localparam logic [2:0] FLT_SHORT    = 3'd3;
    localparam logic [2:0] FLT_LONG     = 3'd4;
    localparam logic [2:0] FLT_DARK     = 3'd5;

    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;

    // Legal order is red -> green -> amber -> red.
    function automatic colour_e successor(colour_e c);
        case (c)
            C_RED:   return C_GREEN;
            C_GREEN: return C_AMBER;
            default: return C_RED;
        endcase
    endfunction

    function automatic lamp_state_e run_state(colour_e c);
        case (c)
            C_GREEN: return S_RUN_GREEN;
            C_AMBER: return S_RUN_AMBER;
            default: return S_RUN_RED;
        endcase
    endfunction

    function automatic lamps_t only(colour_e c);
        lamps_t l;
        l.red   = (c == C_RED)   ? LAMP_ON : LAMP_OFF;
        l.amber = (c == C_AMBER) ? LAMP_ON : LAMP_OFF;
        l.green = (c == C_GREEN) ? LAMP_ON : LAMP_OFF;
        return l;
    endfunction

endpackage

// File: rtl/lamp_flasher.sv
// Square-wave lamp driver: FLASH_HALF cycles on, FLASH_HALF cycles off,
// restarting in the on phase whenever enable rises.
module lamp_flasher #(
    parameter int FLASH_HALF = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic lamp
);
    localparam int HW = $clog2(FLASH_HALF + 1);

    logic [HW-1:0] cnt_q;
    logic          en_q;
    logic          lamp_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            lamp_q <= 1'b0;
        end else begin
            en_q <= enable;
            if (enable && !en_q) begin
                lamp_q <= 1'b1;
                cnt_q  <= HW'(1);
            end else if (enable) begin
                if (cnt_q == HW'(FLASH_HALF)) begin
                    lamp_q <= ~lamp_q;
                    cnt_q  <= HW'(1);
                end else begin
                    cnt_q <= cnt_q + HW'(1);
                end
            end else begin
                lamp_q <= 1'b0;
                cnt_q  <= '0;
            end
        end
    end

    assign lamp = lamp_q;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Lamp safety monitor: mirrors sequencer requests onto the lamps one cycle late
// and latches a fault into flashing-red fail-safe on any illegal pattern.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int RED_TICKS   = 350,
    parameter int GREEN_TICKS = 200,
    parameter int AMBER_TICKS = 10,
    parameter int TOL         = 2,
    parameter int GAP_MAX     = 2,
    parameter int FLASH_HALF  = 4,
    parameter int CW          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       red,
    input  logic       amber,
    input  logic       green,
    input  logic       fault_clear,
    output logic       lamp_red,
    output logic       lamp_amber,
    output logic       lamp_green,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);
    lamp_state_e   state_q, state_d;
    colour_e       expected_q, expected_d;
    logic [CW-1:0] dwell_q, dwell_d, gap_q, gap_d;
    lamps_t        lamp_q, lamp_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d, hit;
    lamps_t        s;
    colour_e       cur;
    logic [CW-1:0] min_dw, max_dw;
    logic          multi, dark, exp_only, flash_lamp;

    assign s        = {red, amber, green};
    assign multi    = $countones(s) > 1;
    assign dark     = (s == '0);
    assign exp_only = (s == only(expected_q));

    always_comb begin
        cur    = C_RED;
        min_dw = CW'(RED_TICKS);
        max_dw = CW'(RED_TICKS + TOL);
        if (state_q == S_RUN_GREEN) begin
            cur    = C_GREEN;
            min_dw = CW'(GREEN_TICKS);
            max_dw = CW'(GREEN_TICKS + TOL);
        end else if (state_q == S_RUN_AMBER) begin
            cur    = C_AMBER;
            min_dw = CW'(AMBER_TICKS);
            max_dw = CW'(AMBER_TICKS + TOL);
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        dwell_d    = dwell_q;
        gap_d      = gap_q;
        fault_d    = fault_q;
        code_d     = code_q;
        hit        = FLT_NONE;
        // Each check below sits in priority order: conflict > sequence > short > long > dark.
        case (state_q)
            S_IDLE: begin
                if (multi) hit = FLT_CONFLICT;
                else if (s == only(C_RED)) begin
                    state_d    = S_RUN_RED;
                    dwell_d    = CW'(1);
                    expected_d = C_GREEN;
                end else if (!dark) hit = FLT_SEQUENCE;
            end
            S_RUN_RED, S_RUN_GREEN, S_RUN_AMBER: begin
                if (multi) hit = FLT_CONFLICT;
                else if (s == only(cur)) begin
                    if (dwell_q >= max_dw)   hit = FLT_LONG;
                    else if (dwell_q != '1)  dwell_d = dwell_q + CW'(1);
                end else if (!dark && !exp_only) hit = FLT_SEQUENCE;
                else if (dwell_q < min_dw)       hit = FLT_SHORT;
                else if (exp_only) begin
                    state_d    = run_state(expected_q);
                    dwell_d    = CW'(1);
                    expected_d = successor(expected_q);
                end else begin
                    state_d = S_GAP;
                    gap_d   = CW'(1);
                end
            end
            S_GAP: begin
                if (multi) hit = FLT_CONFLICT;
                else if (exp_only) begin
                    state_d    = run_state(expected_q);
                    dwell_d    = CW'(1);
                    gap_d      = '0;
                    expected_d = successor(expected_q);
                end else if (!dark)                hit = FLT_SEQUENCE;
                else if (gap_q >= CW'(GAP_MAX))    hit = FLT_DARK;
                else if (gap_q != '1)              gap_d = gap_q + CW'(1);
            end
            S_FAILSAFE: begin
                if (fault_clear && s == only(C_RED)) begin
                    state_d = S_IDLE;
                    fault_d = 1'b0;
                    code_d  = FLT_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hit != FLT_NONE) begin
            state_d = S_FAILSAFE;
            fault_d = 1'b1;
            code_d  = hit;
            dwell_d = '0;
            gap_d   = '0;
        end

        // Running and gap states mirror the sample; IDLE and FAILSAFE park on red.
        if (state_d inside {S_RUN_RED, S_RUN_GREEN, S_RUN_AMBER, S_GAP}) lamp_d = s;
        else                                                             lamp_d = only(C_RED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            expected_q <= C_GREEN;
            dwell_q    <= '0;
            gap_q      <= '0;
            lamp_q     <= only(C_RED);
            fault_q    <= 1'b0;
            code_q     <= FLT_NONE;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            dwell_q    <= dwell_d;
            gap_q      <= gap_d;
            lamp_q     <= lamp_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
        end
    end

    lamp_flasher #(.FLASH_HALF(FLASH_HALF)) u_flasher (
        .clock  (clock),
        .reset  (reset),
        .enable (state_d == S_FAILSAFE),
        .lamp   (flash_lamp)
    );

    assign lamp_red   = (state_q == S_FAILSAFE) ? flash_lamp : lamp_q.red;
    assign lamp_amber = lamp_q.amber;
    assign lamp_green = lamp_q.green;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign flash      = (state_q == S_FAILSAFE);

endmodule

// File: doc/traffic_lamp_monitor.md
Name: traffic_lamp_monitor

Overview:
- Sits directly downstream of the traffic light sequencer. Samples its red/amber/green lamp requests and drives the physical lamp outputs.
- Checks colour exclusivity, sequence order (red→green→amber→red), per-colour dwell time and dark gaps.
- On any violation, latches a fault code and forces fail-safe flashing red until cleared.

Parameters:
- RED_TICKS, 350, minimum legal red dwell in clock cycles.
- GREEN_TICKS, 200, minimum legal green dwell.
- AMBER_TICKS, 10, minimum legal amber dwell.
- TOL, 2, allowed overrun; max dwell = X_TICKS+TOL.
- GAP_MAX, 2, max consecutive all-dark cycles between colours.
- FLASH_HALF, 4, fail-safe red on/off half-period in cycles.
- CW, 16, dwell/gap counter width; must hold RED_TICKS+TOL+1.

Ports:
- clock, input, 1, system clock; all state on posedge.
- reset, input, 1, synchronous active-high reset.
- red, input, 1, sequencer red request.
- amber, input, 1, sequencer amber request.
- green, input, 1, sequencer green request.
- fault_clear, input, 1, one-cycle clear request; honoured only in FAILSAFE.
- lamp_red, output, 1, red lamp drive.
- lamp_amber, output, 1, amber lamp drive.
- lamp_green, output, 1, green lamp drive.
- fault, output, 1, fault latched.
- fault_code, output, 3, 0 none, 1 conflict, 2 sequence, 3 short dwell, 4 long dwell, 5 dark.
- flash, output, 1, high while in FAILSAFE.

Behaviour:
- Reset (wins over everything, including mid-FAILSAFE): state=IDLE, lamp_red=1, lamp_amber=0, lamp_green=0, fault=0, fault_code=0, flash=0, counters=0.
- States: IDLE, RUN_RED, RUN_GREEN, RUN_AMBER, GAP, FAILSAFE. Register expected_next holds the legal successor colour.
- IDLE:
  - Outputs are steady red.
  - Red-only sample → RUN_RED with dwell=1.
  - Amber-only or green-only sample → sequence fault.
  - All-dark samples are tolerated indefinitely; no dark check in IDLE.
- RUN_x:
  - Lamp outputs equal the inputs registered one cycle earlier (latency 1).
  - dwell increments on each sample with x high.
  - Long-dwell fault fires on the sample where dwell would reach X_TICKS+TOL+1.
- Leaving x:
  - At the first sample with x low, dwell < X_TICKS → short-dwell fault.
  - If the successor colour alone is high in that same sample (direct handover): enter RUN_successor, dwell=1.
  - If all lamps are dark: enter GAP, gap=1. Lamp outputs dark.
  - If any other single colour is high: sequence fault.
- GAP:
  - The expected successor alone going high → RUN_successor, dwell=1.
  - Any other single colour → sequence fault.
  - The sample where gap would exceed GAP_MAX → dark fault.
- Conflict: more than one input high in any non-FAILSAFE state → conflict fault.
- Fault priority within one sample: conflict > sequence > short > long > dark.
- Fault entry, on the cycle after the offending sample:
  - fault=1, fault_code set, flash=1, state=FAILSAFE.
  - lamp_amber=lamp_green=0; lamp_red=1 starts the flash.
  - No further detection runs while in FAILSAFE; the code stays frozen.
- FAILSAFE:
  - lamp_red toggles every FLASH_HALF cycles.
  - fault_clear=1 with inputs red-only → next cycle IDLE, fault=0, code=0, flash=0, lamp_red=1 steady.
  - fault_clear with any other input pattern is ignored.
- Counters saturate and never wrap.

Decomposition:
- Shared package traffic_pkg holds:
  - lamp/state enum (IDLE, RUN_RED, RUN_GREEN, RUN_AMBER, GAP, FAILSAFE);
  - colour encoding;
  - fault code constants FLT_NONE..FLT_DARK;
  - on/off constants, shared with the sequencer.
- One sub-module, lamp_flasher: enable input; FLASH_HALF-period toggle output; restarts high on enable rise.

Test Plan:
- Reset, then 3 loops of red 350 / green 200 / amber 10 with direct handover → lamps mirror inputs 1 cycle late; fault=0 throughout.
- Red and green both high at cycle 100 of red → next cycle fault=1, code=1, lamp_green=0, lamp_red pattern 1111 0000 repeating, flash=1.
- Red 350, then amber-only → code=2 on the cycle after amber rises.
- Green 199, then amber → code=3. Separately, green held 203 cycles → code=4 the cycle after the 203rd sample.
- Red off, 3 dark samples → code=5 after the 3rd. 2 dark samples, then green → no fault.
- In FAILSAFE:
  - fault_clear with green-only → ignored.
  - fault_clear with red-only → IDLE, fault=0, steady red.
  - reset pulse during flashing → reset values next cycle.
